// File: rtl/blinky_pkg.sv
// Shared types for the blinky LED monitor and its helpers.
package blinky_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } monitor_state_e;

   localparam int ToggleWidth = 16;
endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, with rise/fall strobes
// derived from the synchronised level and its one-cycle-delayed copy.
module sync_edge_detect #(
   parameter int SyncStages = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   logic [SyncStages-1:0] r_sync;
   logic                  r_level_q;

   // Synchroniser chain plus previous-level register for edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync    <= '0;
         r_level_q <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SyncStages-2:0], d_i};
         r_level_q <= r_sync[SyncStages-1];
      end
   end

   assign level_o = r_sync[SyncStages-1];
   assign rise_o  = r_sync[SyncStages-1] & ~r_level_q;
   assign fall_o  = ~r_sync[SyncStages-1] & r_level_q;
endmodule

// File: rtl/blinky_monitor.sv
// Measures high/low phase lengths of the blinky LED, counts toggles and flags
// out-of-window phases and a stuck LED.
module blinky_monitor import blinky_pkg::*; #(
   parameter int CountWidth   = 32,
   parameter int ExpectedHalf = 10,
   parameter int Tolerance    = 1,
   parameter int StuckLimit   = 50,
   parameter int SyncStages   = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   led_i,
   input  logic                   enable_i,
   input  logic                   clear_i,
   output logic [CountWidth-1:0]  on_cycles_o,
   output logic [CountWidth-1:0]  off_cycles_o,
   output logic                   period_valid_o,
   output logic [ToggleWidth-1:0] toggle_count_o,
   output logic                   period_err_o,
   output logic                   stuck_o
);
   // Window bounds widened by one bit so a small ExpectedHalf cannot underflow
   localparam bit                LoCheck = (ExpectedHalf - Tolerance) > 0;
   localparam logic [CountWidth:0] LoBound =
      LoCheck ? (CountWidth+1)'(ExpectedHalf - Tolerance) : '0;
   localparam logic [CountWidth:0] HiBound = (CountWidth+1)'(ExpectedHalf + Tolerance);

   logic w_level, w_rise, w_fall, w_edge;
   monitor_state_e r_state, w_state_nxt;
   logic [CountWidth-1:0]  r_cnt, w_cnt_nxt;
   logic [CountWidth-1:0]  r_on, r_off;
   logic [ToggleWidth-1:0] r_toggle;
   logic r_valid, r_err, r_stuck, r_measured;
   logic w_in_phase, w_high_done, w_low_done, w_out_of_window, w_new_err;

   sync_edge_detect #(.SyncStages(SyncStages)) u_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .d_i     (led_i),
      .level_o (w_level),
      .rise_o  (w_rise),
      .fall_o  (w_fall)
   );

   assign w_edge      = w_rise | w_fall;
   assign w_in_phase  = (r_state == HIGH) || (r_state == LOW);
   assign w_high_done = enable_i && (r_state == HIGH) && w_fall;
   assign w_low_done  = enable_i && (r_state == LOW) && w_rise;
   assign w_out_of_window = (LoCheck && ({1'b0, r_cnt} < LoBound)) || ({1'b0, r_cnt} > HiBound);
   assign w_new_err   = (w_high_done || w_low_done) && w_out_of_window;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; dropping enable always returns to IDLE
   always_comb begin
      w_state_nxt = r_state;
      if (!enable_i) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_state_nxt = ARM;
            ARM:     if (w_edge) w_state_nxt = w_level ? HIGH : LOW;
                     else        w_state_nxt = ARM;
            HIGH:    if (w_fall) w_state_nxt = LOW;
                     else        w_state_nxt = HIGH;
            LOW:     if (w_rise) w_state_nxt = HIGH;
                     else        w_state_nxt = LOW;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Phase counter: restarts at 1 on each edge, saturates instead of wrapping
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (!enable_i || (r_state == IDLE)) begin
         w_cnt_nxt = '0;
      end else if (w_edge) begin
         w_cnt_nxt = CountWidth'(1);
      end else if (r_cnt == {CountWidth{1'b1}}) begin
         w_cnt_nxt = r_cnt;
      end else begin
         w_cnt_nxt = r_cnt + CountWidth'(1);
      end
   end

   // Measurement, toggle, error and stuck registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt      <= '0;
         r_on       <= '0;
         r_off      <= '0;
         r_toggle   <= '0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_stuck    <= 1'b0;
         r_measured <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_valid <= 1'b0;
         if (!enable_i || (r_state == IDLE)) begin
            r_measured <= 1'b0;
         end else if (w_high_done) begin
            r_on       <= r_cnt;
            r_measured <= 1'b1;
         end else if (w_low_done) begin
            r_off   <= r_cnt;
            r_valid <= r_measured;
         end
         if (enable_i && w_edge && (r_state != IDLE)) begin
            r_toggle <= r_toggle + ToggleWidth'(1);
         end
         if (w_new_err) begin
            r_err <= 1'b1;
         end else if (clear_i) begin
            r_err <= 1'b0;
         end
         if (!enable_i) begin
            r_stuck <= 1'b0;
         end else if (w_in_phase && w_edge) begin
            r_stuck <= 1'b0;
         end else if (w_in_phase && (w_cnt_nxt >= CountWidth'(StuckLimit))) begin
            r_stuck <= 1'b1;
         end
      end
   end

   assign on_cycles_o    = r_on;
   assign off_cycles_o   = r_off;
   assign period_valid_o = r_valid;
   assign toggle_count_o = r_toggle;
   assign period_err_o   = r_err;
   assign stuck_o        = r_stuck;
endmodule
